pe_run_ctrl: RTL and testbench

// Run sequencer for the reversible multiply-accumulate PE datapath. On a host START it streams
// LEN operands out of the input buffer and tracks them through the PE pipeline. It generates the

---
 rtl/pe_pkg.sv | 20 ++
 rtl/pe_sat_cnt.sv | 36 +++
 rtl/pe_run_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pe_run_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the reversible MAC PE run control.
package pe_pkg;

    localparam int PE_DATA_NUM = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } run_state_e;

    // Host command codes as decoded from the SPI front end.
    typedef enum logic [1:0] {
        NO_CMD    = 2'b00,
        START_CMD = 2'b01,
        WRITE_CMD = 2'b10
    } pe_cmd_e;

endpackage

// File: rtl/pe_sat_cnt.sv
// Saturating event counter: synchronous clear wins over increment, sticks at all-ones.
module pe_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, or add one unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pe_run_ctrl.sv
// Run sequencer for the reversible MAC PE: streams operands out of the input
// buffer, tracks them through the pipeline to output-buffer writes, and counts
// reverse-check error flags while the run is active.
//
// state | meaning
// IDLE  | waiting for start; host readback allowed
// ISSUE | one input-buffer read per cycle, addresses 0..len-1
// DRAIN | all reads issued, waiting for the last write to leave the pipeline
// DONE  | single cycle, done_o pulse
module pe_run_ctrl
    import pe_pkg::*;
#(
    parameter int DATA_NUM = PE_DATA_NUM,
    parameter int ADDR_W   = $clog2(DATA_NUM),
    parameter int PIPE_LAT = 3,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [ADDR_W:0]     len_i,
    input  logic                abort_i,
    input  logic                err1_i,
    input  logic                err2_i,
    output logic                in_ren_o,
    output logic [ADDR_W-1:0]   in_raddr_o,
    output logic                pe_en_o,
    output logic                out_wen_o,
    output logic [ADDR_W-1:0]   out_waddr_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                rd_allow_o,
    output logic [ERRCNT_W-1:0] err1_cnt_o,
    output logic [ERRCNT_W-1:0] err2_cnt_o,
    output logic                aborted_o
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DATA_NUM);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    run_state_e          state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [PIPE_LAT-1:0] vld_q, vld_d;
    logic                aborted_q, aborted_d;

    logic            start_acc;
    logic            active;
    logic            abort_acc;
    logic            in_ren;
    logic            wen;
    logic [ADDR_W:0] len_m1;
    logic            last_rd;
    logic            last_wr;

    // Qualified controls and end-of-stream detection shared by FSM and datapath.
    always_comb begin
        start_acc = start_i && (state_q == IDLE);
        active    = (state_q == ISSUE) || (state_q == DRAIN);
        abort_acc = abort_i && active;
        in_ren    = (state_q == ISSUE);
        wen       = vld_q[PIPE_LAT-1];
        len_m1    = len_q - LEN_ONE;
        last_rd   = in_ren && ({1'b0, raddr_q} == len_m1);
        last_wr   = wen && ({1'b0, waddr_q} == len_m1);
    end

    // Next-state logic; abort takes priority over normal progress.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (last_rd) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (last_wr) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Run length, address counters, valid pipeline and abort flag.
    always_comb begin
        len_d     = len_q;
        raddr_d   = raddr_q;
        waddr_d   = waddr_q;
        aborted_d = aborted_q;
        vld_d     = (vld_q << 1) | PIPE_LAT'(in_ren);
        if (start_acc) begin
            len_d     = (len_i > LEN_MAX) ? LEN_MAX : len_i;
            raddr_d   = '0;
            waddr_d   = '0;
            aborted_d = 1'b0;
        end else begin
            if (in_ren) begin
                raddr_d = raddr_q + ADDR_W'(1);
            end
            if (wen) begin
                waddr_d = waddr_q + ADDR_W'(1);
            end
            if (abort_acc) begin
                aborted_d = 1'b1;
            end
        end
        // Operands still in flight are discarded so nothing lands in the output buffer.
        if (abort_acc) begin
            vld_d = '0;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            vld_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            raddr_q   <= raddr_d;
            waddr_q   <= waddr_d;
            vld_q     <= vld_d;
            aborted_q <= aborted_d;
        end
    end

    pe_sat_cnt #(.W(ERRCNT_W)) u_err1_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (start_acc),
        .inc_i (err1_i && active),
        .cnt_o (err1_cnt_o)
    );

    pe_sat_cnt #(.W(ERRCNT_W)) u_err2_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (start_acc),
        .inc_i (err2_i && active),
        .cnt_o (err2_cnt_o)
    );

    assign in_ren_o    = in_ren;
    assign in_raddr_o  = raddr_q;
    assign out_wen_o   = wen;
    assign out_waddr_o = waddr_q;
    assign busy_o      = active;
    assign pe_en_o     = active;
    assign done_o      = (state_q == DONE);
    assign rd_allow_o  = (state_q == IDLE);
    assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_pe_run_ctrl.sv
// Directed bench for pe_run_ctrl; a second instance with a long pipeline
// exercises error-counter saturation within a single run.
module tb_pe_run_ctrl;

    localparam int PL     = 3;
    localparam int PL_SAT = 284;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic [4:0] len_i;
    logic       abort_i;
    logic       err1_i;
    logic       err2_i;

    logic       in_ren_o, pe_en_o, out_wen_o, busy_o, done_o, rd_allow_o, aborted_o;
    logic [3:0] in_raddr_o, out_waddr_o;
    logic [7:0] err1_cnt_o, err2_cnt_o;

    logic       s_in_ren, s_pe_en, s_out_wen, s_busy, s_done, s_rd_allow, s_aborted;
    logic [3:0] s_in_raddr, s_out_waddr;
    logic [7:0] s_err1_cnt, s_err2_cnt;

    logic [14:0] outs_vec;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pe_run_ctrl #(.PIPE_LAT(PL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .len_i       (len_i),
        .abort_i     (abort_i),
        .err1_i      (err1_i),
        .err2_i      (err2_i),
        .in_ren_o    (in_ren_o),
        .in_raddr_o  (in_raddr_o),
        .pe_en_o     (pe_en_o),
        .out_wen_o   (out_wen_o),
        .out_waddr_o (out_waddr_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_allow_o  (rd_allow_o),
        .err1_cnt_o  (err1_cnt_o),
        .err2_cnt_o  (err2_cnt_o),
        .aborted_o   (aborted_o)
    );

    pe_run_ctrl #(.PIPE_LAT(PL_SAT)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .len_i       (len_i),
        .abort_i     (abort_i),
        .err1_i      (err1_i),
        .err2_i      (err2_i),
        .in_ren_o    (s_in_ren),
        .in_raddr_o  (s_in_raddr),
        .pe_en_o     (s_pe_en),
        .out_wen_o   (s_out_wen),
        .out_waddr_o (s_out_waddr),
        .busy_o      (s_busy),
        .done_o      (s_done),
        .rd_allow_o  (s_rd_allow),
        .err1_cnt_o  (s_err1_cnt),
        .err2_cnt_o  (s_err2_cnt),
        .aborted_o   (s_aborted)
    );

    // {in_ren, raddr, pe_en, wen, waddr, busy, done, rd_allow, aborted}; reset value is 15'h2
    assign outs_vec = {in_ren_o, in_raddr_o, pe_en_o, out_wen_o, out_waddr_o,
                       busy_o, done_o, rd_allow_o, aborted_o};

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a run with len_in (n = effective length) and check every cycle to one past done.
    task automatic run_len(input int len_in, input int n, input bit ab);
        int  done_c;
        bit  ren_e, wen_e, busy_e, done_e;
        done_c  = (n == 0) ? 1 : n + PL + 1;
        start_i = 1'b1;
        len_i   = 5'(len_in);
        abort_i = ab;
        for (int c = 1; c <= done_c + 1; c++) begin
            step();
            start_i = 1'b0;
            abort_i = 1'b0;
            ren_e  = (c <= n);
            wen_e  = (c >= PL + 1) && (c <= n + PL);
            busy_e = (n > 0) && (c <= n + PL);
            done_e = (c == done_c);
            chk("in_ren", c, in_ren_o, ren_e);
            if (ren_e) chk("in_raddr", c, in_raddr_o, c - 1);
            chk("out_wen", c, out_wen_o, wen_e);
            if (wen_e) chk("out_waddr", c, out_waddr_o, c - PL - 1);
            chk("busy", c, busy_o, busy_e);
            chk("pe_en", c, pe_en_o, busy_e);
            chk("done", c, done_o, done_e);
            chk("rd_allow", c, rd_allow_o, !(busy_e || done_e));
            if (c == 1) chk("aborted_clr", c, aborted_o, 0);
        end
    endtask

    initial begin
        int c;
        bit seen;
        bit any_ren, any_wen, any_done;

        rst_n = 1'b0; start_i = 1'b0; len_i = '0; abort_i = 1'b0; err1_i = 1'b0; err2_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 0, outs_vec, 32'h2);
        chk("reset_errs", 0, {err1_cnt_o, err2_cnt_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Saturation: err1 held through a 300-cycle run of the long-pipeline instance.
        start_i = 1'b1; len_i = 5'd16; err1_i = 1'b1;
        c = 0; seen = 1'b0;
        while (!seen && c < 400) begin
            step();
            c++;
            start_i = 1'b0;
            err2_i  = (c == 2 || c == 5 || c == 10);
            if (s_done) seen = 1'b1;
        end
        err1_i = 1'b0; err2_i = 1'b0;
        chk("sat_done_cycle", c, c, 301);
        step();
        chk("sat_err1", 0, s_err1_cnt, 255);
        chk("sat_err2", 0, s_err2_cnt, 3);
        chk("main_err1", 0, err1_cnt_o, 19);
        chk("main_err2", 0, err2_cnt_o, 3);

        // Zero-length run: done next cycle, counters cleared, nothing read or written.
        run_len(0, 0, 1'b0);
        chk("len0_err1_clr", 0, err1_cnt_o, 0);
        chk("len0_err2_clr", 0, err2_cnt_o, 0);

        run_len(4, 4, 1'b0);
        run_len(16, 16, 1'b0);
        run_len(20, 16, 1'b0);

        // Abort at cycle 3 of a len=8 run, with an ignored second start at cycle 2.
        start_i = 1'b1; len_i = 5'd8;
        step();
        start_i = 1'b0;
        chk("ab_raddr_c1", 1, in_raddr_o, 0);
        step();
        start_i = 1'b1; len_i = 5'd2;
        chk("ab_raddr_c2", 2, in_raddr_o, 1);
        step();
        start_i = 1'b0;
        chk("ab_raddr_c3", 3, in_raddr_o, 2);
        chk("ab_busy_c3", 3, busy_o, 1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("ab_busy_c4", 4, busy_o, 0);
        chk("ab_rd_allow_c4", 4, rd_allow_o, 1);
        chk("ab_aborted_c4", 4, aborted_o, 1);
        any_ren = 1'b0; any_wen = 1'b0; any_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            any_ren  |= in_ren_o;
            any_wen  |= out_wen_o;
            any_done |= done_o;
            step();
        end
        chk("ab_no_ren", 4, any_ren, 0);
        chk("ab_no_wen", 4, any_wen, 0);
        chk("ab_no_done", 4, any_done, 0);
        chk("ab_aborted_hold", 16, aborted_o, 1);

        // Async reset in the middle of DRAIN.
        start_i = 1'b1; len_i = 5'd4;
        step();
        start_i = 1'b0;
        chk("rs_aborted_clr", 1, aborted_o, 0);
        repeat (4) step();
        chk("rs_drain_busy", 5, busy_o, 1);
        chk("rs_drain_wen", 5, out_wen_o, 1);
        chk("rs_drain_waddr", 5, out_waddr_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_outs", 5, outs_vec, 32'h2);
        chk("rs_errs", 5, {err1_cnt_o, err2_cnt_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fresh run after reset, with abort coincident with start (start wins).
        run_len(2, 2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
